// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_forward_unit_pkg                                              |
// | Shared forwarding-select encodings and pipeline stage control record |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hazard_forward_unit_pkg;

    // Stage records are sized for the widest supported register file; narrower
    // address spaces are zero-extended into them.
    localparam int STAGE_ADDR_W = 8;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    typedef struct packed {
        logic                    valid;
        logic [STAGE_ADDR_W-1:0] rd;
        logic                    wb_en;
        logic                    mem_read;
        logic                    mem_write;
        logic [STAGE_ADDR_W-1:0] rs2;
    } stage_ctrl_t;

    function automatic logic [1:0] fwd_select(
        input logic use_src,
        input logic hit_ex,
        input logic ex_is_load,
        input logic hit_mem
    );
        if (!use_src)
            return FWD_REGFILE;
        if (hit_ex && !ex_is_load)
            return FWD_EXMEM;
        if (hit_mem)
            return FWD_MEMWB;
        return FWD_REGFILE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_match                                                         |
// | Source-register vs. stage-destination comparator                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_match
    import hazard_forward_unit_pkg::*;
#(
    parameter int ZERO_REG_EN = 0
) (
    input  logic [STAGE_ADDR_W-1:0] addr,
    input  logic                    stage_valid,
    input  logic                    stage_wb_en,
    input  logic [STAGE_ADDR_W-1:0] stage_rd,
    output logic                    hit
);

    logic w_addr_eq;
    logic w_zero_reg;

    assign w_addr_eq  = (addr == stage_rd);
    assign w_zero_reg = (ZERO_REG_EN != 0) && (addr == '0);
    assign hit        = stage_valid && stage_wb_en && w_addr_eq && !w_zero_reg;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_forward_unit                                                  |
// | EX/MEM/WB shadow tracking, forwarding selects, load-use and MEM stall|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_LAT     = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  mem_stall,
    output logic [1:0]            fwd_rs1,
    output logic [1:0]            fwd_rs2,
    output logic                  fwd_store_data
);

    stage_ctrl_t r_s_ex;
    stage_ctrl_t r_s_mem;
    stage_ctrl_t r_s_wb;
    stage_ctrl_t w_id_entry;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_fwd_rs1;
    logic [1:0]       r_fwd_rs2;
    logic             r_fwd_store;

    logic [STAGE_ADDR_W-1:0] w_rs1_x;
    logic [STAGE_ADDR_W-1:0] w_rs2_x;
    logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem, w_st_mem;
    logic w_mem_op, w_cnt_busy, w_mem_stall, w_load_use, w_bubble, w_ex_kill;
    logic w_unused;

    assign w_rs1_x = STAGE_ADDR_W'(id_rs1);
    assign w_rs2_x = STAGE_ADDR_W'(id_rs2);

    hazard_match #(.ZERO_REG_EN(ZERO_REG_EN)) u_rs1_ex (
        .addr(w_rs1_x), .stage_valid(r_s_ex.valid), .stage_wb_en(r_s_ex.wb_en),
        .stage_rd(r_s_ex.rd), .hit(w_rs1_ex)
    );
    hazard_match #(.ZERO_REG_EN(ZERO_REG_EN)) u_rs2_ex (
        .addr(w_rs2_x), .stage_valid(r_s_ex.valid), .stage_wb_en(r_s_ex.wb_en),
        .stage_rd(r_s_ex.rd), .hit(w_rs2_ex)
    );
    hazard_match #(.ZERO_REG_EN(ZERO_REG_EN)) u_rs1_mem (
        .addr(w_rs1_x), .stage_valid(r_s_mem.valid), .stage_wb_en(r_s_mem.wb_en),
        .stage_rd(r_s_mem.rd), .hit(w_rs1_mem)
    );
    hazard_match #(.ZERO_REG_EN(ZERO_REG_EN)) u_rs2_mem (
        .addr(w_rs2_x), .stage_valid(r_s_mem.valid), .stage_wb_en(r_s_mem.wb_en),
        .stage_rd(r_s_mem.rd), .hit(w_rs2_mem)
    );
    // Store in EX whose data register is being loaded by the instruction in MEM.
    hazard_match #(.ZERO_REG_EN(ZERO_REG_EN)) u_store_mem (
        .addr(r_s_ex.rs2), .stage_valid(r_s_mem.valid), .stage_wb_en(r_s_mem.wb_en),
        .stage_rd(r_s_mem.rd), .hit(w_st_mem)
    );

    generate
        if (MEM_LAT > 1) begin : g_lat_multi
            localparam logic [CNT_W-1:0] c_lat_last = CNT_W'(MEM_LAT - 1);
            assign w_cnt_busy = (r_cnt < c_lat_last);
        end else begin : g_lat_single
            assign w_cnt_busy = 1'b0;
        end
    endgenerate

    assign w_mem_op    = r_s_mem.valid && (r_s_mem.mem_read || r_s_mem.mem_write);
    assign w_mem_stall = w_mem_op && w_cnt_busy;
    assign w_load_use  = id_valid && r_s_ex.mem_read &&
                         ((id_uses_rs1 && w_rs1_ex) ||
                          (id_uses_rs2 && !id_mem_write && w_rs2_ex));
    assign w_bubble    = flush || w_load_use;
    assign w_ex_kill   = w_bubble || !id_valid;

    assign stall_if_id    = w_mem_stall || w_load_use;
    assign bubble_ex      = !w_mem_stall && w_bubble;
    assign mem_stall      = w_mem_stall;
    assign fwd_rs1        = r_fwd_rs1;
    assign fwd_rs2        = r_fwd_rs2;
    assign fwd_store_data = r_fwd_store;

    always_comb begin
        w_id_entry           = '0;
        w_id_entry.valid     = 1'b1;
        w_id_entry.rd        = STAGE_ADDR_W'(id_rd);
        w_id_entry.wb_en     = id_wb_en;
        w_id_entry.mem_read  = id_mem_read;
        w_id_entry.mem_write = id_mem_write;
        w_id_entry.rs2       = w_rs2_x;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_ex      <= '0;
            r_s_mem     <= '0;
            r_s_wb      <= '0;
            r_cnt       <= '0;
            r_fwd_rs1   <= FWD_REGFILE;
            r_fwd_rs2   <= FWD_REGFILE;
            r_fwd_store <= 1'b0;
        end else if (w_mem_stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt       <= '0;
            r_s_wb      <= r_s_mem;
            r_s_mem     <= r_s_ex;
            r_s_ex      <= w_ex_kill ? '0 : w_id_entry;
            r_fwd_rs1   <= w_ex_kill ? FWD_REGFILE :
                           fwd_select(id_uses_rs1, w_rs1_ex, r_s_ex.mem_read, w_rs1_mem);
            r_fwd_rs2   <= w_ex_kill ? FWD_REGFILE :
                           fwd_select(id_uses_rs2, w_rs2_ex, r_s_ex.mem_read, w_rs2_mem);
            r_fwd_store <= r_s_ex.valid && r_s_ex.mem_write && r_s_mem.mem_read && w_st_mem;
        end
    end

    // The WB shadow and the MEM-stage rs2 are tracked but no select consumes them.
    assign w_unused = ^{r_s_wb, r_s_mem.rs2};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_forward_unit                                               |
// | Directed bench: default, MEM_LAT=3 and ZERO_REG_EN=1 instances       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       id_wb_en, id_mem_read, id_mem_write, flush;

    logic       stall0, bub0, ms0, fs0;
    logic [1:0] f1_0, f2_0;
    logic       stall3, bub3, ms3, fs3;
    logic [1:0] f1_3, f2_3;
    logic       stallz, bubz, msz, fsz;
    logic [1:0] f1_z, f2_z;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(3), .MEM_LAT(1), .ZERO_REG_EN(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .stall_if_id(stall0), .bubble_ex(bub0), .mem_stall(ms0),
        .fwd_rs1(f1_0), .fwd_rs2(f2_0), .fwd_store_data(fs0)
    );

    hazard_forward_unit #(.REG_ADDR_W(3), .MEM_LAT(3), .ZERO_REG_EN(0), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .stall_if_id(stall3), .bubble_ex(bub3), .mem_stall(ms3),
        .fwd_rs1(f1_3), .fwd_rs2(f2_3), .fwd_store_data(fs3)
    );

    hazard_forward_unit #(.REG_ADDR_W(3), .MEM_LAT(1), .ZERO_REG_EN(1), .CNT_W(4)) u_dutz (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .stall_if_id(stallz), .bubble_ex(bubz), .mem_stall(msz),
        .fwd_rs1(f1_z), .fwd_rs2(f2_z), .fwd_store_data(fsz)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                         input logic wb, input logic mr, input logic mw, input logic fl);
        id_valid = v;  id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd;    id_wb_en = wb; id_mem_read = mr; id_mem_write = mw; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        #2;
        chk("rst_stall", stall0, 0); chk("rst_bubble", bub0, 0); chk("rst_mstall", ms0, 0);
        chk("rst_fwd1", f1_0, 0);    chk("rst_fwd2", f2_0, 0);   chk("rst_fsd", fs0, 0);
        tick(); tick();
        reset = 1'b0;

        // ALU chain: add r3; add r4 <- r3; add r6 <- r3, r4
        drive(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0); #1; chk("alu0_stall", stall0, 0); tick();
        chk("alu0_fwd1", f1_0, 2'b00);
        drive(1, 3'd3, 1, 3'd5, 1, 3'd4, 1, 0, 0, 0); #1; chk("alu1_stall", stall0, 0); tick();
        chk("alu1_fwd1", f1_0, 2'b10); chk("alu1_fwd2", f2_0, 2'b00);
        drive(1, 3'd3, 1, 3'd4, 1, 3'd6, 1, 0, 0, 0); #1; chk("alu2_stall", stall0, 0); tick();
        chk("alu2_fwd1", f1_0, 2'b01); chk("alu2_fwd2", f2_0, 2'b10);
        idle(); tick(); chk("alu_idle_fwd2", f2_0, 2'b00); tick(); tick();

        // Load-use: lw r2; add r7 <- r1, r2
        drive(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 1, 0, 0); tick();
        drive(1, 3'd1, 1, 3'd2, 1, 3'd7, 1, 0, 0, 0); #1;
        chk("lu_stall", stall0, 1); chk("lu_bubble", bub0, 1); tick();
        chk("lu_bub_fwd2", f2_0, 2'b00); chk("lu_stall_clear", stall0, 0); chk("lu_bubble_clear", bub0, 0);
        tick();
        chk("lu_fwd2", f2_0, 2'b01); chk("lu_fwd1", f1_0, 2'b00);
        idle(); tick(); tick(); tick();

        // Store after load: lw r5; sw rs2=r5
        drive(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 1, 0, 0); tick();
        drive(1, 3'd1, 1, 3'd5, 1, 3'd0, 0, 0, 1, 0); #1; chk("st_stall", stall0, 0); tick();
        chk("st_fwd2", f2_0, 2'b00); chk("st_fsd_ex", fs0, 0);
        idle(); tick(); chk("st_fsd_mem", fs0, 1);
        tick(); chk("st_fsd_after", fs0, 0);
        tick(); tick();

        // Flush coincident with load-use, then flush alone
        drive(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 1, 0, 0); tick();
        drive(1, 3'd2, 1, 3'd0, 0, 3'd3, 1, 0, 0, 1); #1;
        chk("fl_lu_stall", stall0, 1); chk("fl_lu_bubble", bub0, 1); tick();
        chk("fl_lu_fwd1", f1_0, 2'b00);
        drive(1, 3'd2, 1, 3'd0, 0, 3'd4, 1, 0, 0, 0); #1;
        chk("fl_next_stall", stall0, 0); chk("fl_next_bubble", bub0, 0); tick();
        chk("fl_next_fwd1", f1_0, 2'b01);
        drive(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 0, 0, 1); #1;
        chk("fl_only_bubble", bub0, 1); chk("fl_only_stall", stall0, 0); tick();
        drive(1, 3'd5, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0); tick();
        chk("fl_killed_fwd1", f1_0, 2'b00);
        idle(); tick(); tick(); tick();

        // MEM_LAT = 3 instance
        reset = 1'b1; #1;
        chk("l3_rst_mstall", ms3, 0); chk("l3_rst_fwd1", f1_3, 0);
        tick(); reset = 1'b0;
        drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 0); tick();
        drive(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 1, 0, 0); #1; chk("l3_ms_a", ms3, 0); tick();
        chk("l3_fwd1_a", f1_3, 2'b10);
        drive(1, 3'd1, 1, 3'd0, 0, 3'd3, 1, 1, 0, 0); #1; chk("l3_ms_b", ms3, 0); tick();
        chk("l3_fwd1_b", f1_3, 2'b01);
        drive(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0, 0); #1;
        chk("l3_ms_c1", ms3, 1); chk("l3_stall_c1", stall3, 1); chk("l3_bubble_c1", bub3, 0); tick();
        chk("l3_ms_c2", ms3, 1); chk("l3_frozen_fwd1", f1_3, 2'b01); tick();
        chk("l3_ms_c3", ms3, 0); chk("l3_lu_stall", stall3, 1); chk("l3_lu_bubble", bub3, 1);
        chk("l3_frozen_fwd1_b", f1_3, 2'b01); tick();
        chk("l3_ms_d1", ms3, 1); chk("l3_bub_fwd1", f1_3, 2'b00); chk("l3_bubble_d1", bub3, 0); tick();
        chk("l3_ms_d2", ms3, 1); tick();
        chk("l3_ms_d3", ms3, 0); chk("l3_stall_d3", stall3, 0); chk("l3_bubble_d3", bub3, 0); tick();
        chk("l3_fwd1_y", f1_3, 2'b01); chk("l3_ms_e", ms3, 0);
        idle(); tick(); tick(); tick();

        // Reset during a memory stall
        drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0); tick();
        drive(1, 3'd5, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0); tick();
        chk("rs_ms_1", ms3, 1); chk("rs_fwd1_pre", f1_3, 2'b00); tick();
        chk("rs_ms_2", ms3, 1);
        #2; reset = 1'b1; #1;
        chk("rs_mstall", ms3, 0); chk("rs_stall", stall3, 0); chk("rs_bubble", bub3, 0);
        chk("rs_fwd1", f1_3, 0);  chk("rs_fwd2", f2_3, 0);    chk("rs_fsd", fs3, 0);
        tick(); reset = 1'b0;
        drive(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0, 0); #1;
        chk("rs_first_stall", stall3, 0); chk("rs_first_ms", ms3, 0); tick();
        idle(); tick(); chk("rs_again_ms1", ms3, 1);
        tick(); chk("rs_again_ms2", ms3, 1);
        tick(); chk("rs_again_ms3", ms3, 0);
        tick(); tick();

        // ZERO_REG_EN = 1 instance (default instance shown for contrast)
        reset = 1'b1; #1; tick(); reset = 1'b0;
        drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, 0); tick();
        drive(1, 3'd0, 1, 3'd0, 1, 3'd1, 1, 0, 0, 0); #1; chk("z_alu_stall", stallz, 0); tick();
        chk("z_fwd1", f1_z, 2'b00); chk("z_fwd2", f2_z, 2'b00); chk("z_ref_fwd1", f1_0, 2'b10);
        idle(); tick(); tick(); tick();
        drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0, 0); tick();
        drive(1, 3'd0, 1, 3'd0, 0, 3'd2, 1, 0, 0, 0); #1;
        chk("z_lu_stall", stallz, 0); chk("z_lu_bubble", bubz, 0); chk("z_ref_lu_stall", stall0, 1);
        tick();
        chk("z_lu_fwd1", f1_z, 2'b00); chk("z_ms", msz, 0);
        idle(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
